circle_raster: RTL



---
 rtl/circle_raster.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/circle_raster.sv
// Midpoint-circle rasteriser: walks one octant and emits up to four clipped
// horizontal spans per step over a valid/ready pixel stream.
//
// state     | meaning
// IDLE      | waiting for start; latches centre, radius, mode and colour
// SETUP     | x=0, y=rad, d=1-rad, first span
// SPAN_INIT | compute row and clipped endpoints of the current span
// SPAN_RUN  | present pixels until the last one of the span is accepted
// NEXT      | advance to the next of the four spans
// STEP      | midpoint update, loop while x<=y
// DONE      | one-cycle completion pulse
module circle_raster #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    fill,
  input  logic                    abort,
  input  logic [WIDTH_BITS-1:0]   xC,
  input  logic [HEIGHT_BITS-1:0]  yC,
  input  logic [WIDTH_BITS-1:0]   rad,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    pix_ready,
  output logic                    pix_valid,
  output logic [WIDTH_BITS-1:0]   X,
  output logic [HEIGHT_BITS-1:0]  Y,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    busy,
  output logic                    done
);

  // One signed width for all coordinate and decision math, wide enough that
  // yC + radius or xC + radius can never wrap before clipping.
  localparam int CW = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 3;
  localparam logic signed [CW-1:0] ZERO  = '0;
  localparam logic signed [CW-1:0] ONE   = CW'(1);
  localparam logic signed [CW-1:0] THREE = CW'(3);
  localparam logic signed [CW-1:0] FIVE  = CW'(5);
  localparam logic signed [CW-1:0] W_MAX = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] H_MAX = CW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SPAN_INIT, SPAN_RUN, NEXT, STEP, DONE
  } state_t;

  state_t state_q, state_d;

  logic                    fill_q;
  logic [WIDTH_BITS-1:0]   xc_q, rad_q;
  logic [HEIGHT_BITS-1:0]  yc_q;
  logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;
  logic signed [CW-1:0]    x_q, y_q, d_q;
  logic [1:0]              sidx_q;
  logic [WIDTH_BITS-1:0]   cur_q, last_q;
  logic [HEIGHT_BITS-1:0]  row_q;

  logic signed [CW-1:0]    xcs, ycs, rad_s;
  logic signed [CW-1:0]    row_c, half_c, xl_c, xr_c, cl_c, cr_c;
  logic signed [CW-1:0]    x_nx, y_nx, d_nx;
  logic                    left_ok, right_ok, row_ok, empty_c, skip_c;
  logic [WIDTH_BITS-1:0]   first_c, last_c;

  assign xcs   = $signed({{(CW-WIDTH_BITS){1'b0}}, xc_q});
  assign ycs   = $signed({{(CW-HEIGHT_BITS){1'b0}}, yc_q});
  assign rad_s = $signed({{(CW-WIDTH_BITS){1'b0}}, rad_q});

  always_comb begin
    row_c  = ycs + y_q;
    half_c = x_q;
    case (sidx_q)
      2'd1: begin row_c = ycs + x_q; half_c = y_q; end
      2'd2: begin row_c = ycs - x_q; half_c = y_q; end
      2'd3: begin row_c = ycs - y_q; half_c = x_q; end
      default: ;
    endcase
    xl_c     = xcs - half_c;
    xr_c     = xcs + half_c;
    cl_c     = (xl_c < ZERO) ? ZERO : xl_c;
    cr_c     = (xr_c > W_MAX) ? W_MAX : xr_c;
    left_ok  = (xl_c >= ZERO) && (xl_c <= W_MAX);
    right_ok = (xr_c >= ZERO) && (xr_c <= W_MAX);
    row_ok   = (row_c >= ZERO) && (row_c <= H_MAX);
    if (fill_q) begin
      first_c = cl_c[WIDTH_BITS-1:0];
      last_c  = cr_c[WIDTH_BITS-1:0];
      empty_c = cl_c > cr_c;
    end else begin
      // Outline: only on-screen original endpoints; one pixel when only one survives.
      first_c = left_ok  ? xl_c[WIDTH_BITS-1:0] : xr_c[WIDTH_BITS-1:0];
      last_c  = right_ok ? xr_c[WIDTH_BITS-1:0] : xl_c[WIDTH_BITS-1:0];
      empty_c = !left_ok && !right_ok;
    end
    skip_c = !row_ok || empty_c || ((sidx_q == 2'd2) && (x_q == ZERO));
  end

  always_comb begin
    if (d_q < ZERO) begin
      d_nx = d_q + (x_q <<< 1) + THREE;
      y_nx = y_q;
    end else begin
      d_nx = d_q + ((x_q - y_q) <<< 1) + FIVE;
      y_nx = y_q - ONE;
    end
    x_nx = x_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pix_valid = (state_q == SPAN_RUN);
    busy      = (state_q != IDLE) && (state_q != DONE);
    done      = (state_q == DONE);
    case (state_q)
      IDLE:      if (start) state_d = SETUP;
      SETUP:     state_d = SPAN_INIT;
      SPAN_INIT: state_d = skip_c ? NEXT : SPAN_RUN;
      SPAN_RUN:  if (pix_ready && (cur_q == last_q)) state_d = NEXT;
      NEXT: begin
        // A zero radius would repeat the centre in every span, so stop after the first.
        if (rad_q == '0)          state_d = DONE;
        else if (sidx_q == 2'd3)  state_d = STEP;
        else                      state_d = SPAN_INIT;
      end
      STEP:      state_d = (x_nx <= y_nx) ? SPAN_INIT : DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 1'b0;
      xc_q   <= '0;
      yc_q   <= '0;
      rad_q  <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      x_q    <= ZERO;
      y_q    <= ZERO;
      d_q    <= ZERO;
      sidx_q <= 2'd0;
      cur_q  <= '0;
      last_q <= '0;
      row_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          fill_q <= fill;
          xc_q   <= xC;
          yc_q   <= yC;
          rad_q  <= rad;
          r_q    <= r_i;
          g_q    <= g_i;
          b_q    <= b_i;
        end
        SETUP: begin
          x_q    <= ZERO;
          y_q    <= rad_s;
          d_q    <= ONE - rad_s;
          sidx_q <= 2'd0;
        end
        SPAN_INIT: if (!skip_c) begin
          cur_q  <= first_c;
          last_q <= last_c;
          row_q  <= row_c[HEIGHT_BITS-1:0];
        end
        SPAN_RUN: if (pix_ready && (cur_q != last_q)) begin
          cur_q <= fill_q ? cur_q + WIDTH_BITS'(1) : last_q;
        end
        NEXT: sidx_q <= sidx_q + 2'd1;
        STEP: begin
          x_q    <= x_nx;
          y_q    <= y_nx;
          d_q    <= d_nx;
          sidx_q <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign X   = cur_q;
  assign Y   = row_q;
  assign r_o = r_q;
  assign g_o = g_q;
  assign b_o = b_q;

endmodule
